// File: rtl/feature_layer_scheduler.sv
// Layer sequencer for the feature memory controller.
// Holds a per-layer descriptor table (CLP_type, feature_amount, output_amount)
// and runs layers back-to-back with ping-pong read/write regions.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   cfg_we/cfg_layer/cfg_*   descriptor write port (ignored while busy)
//   num_layers, start        run request (start ignored while busy)
//   CLP_output_flag          one output word written by the datapath
//   busy, done               run status (done is a 1-cycle pulse)
//   state                    layer-active level to the feature memory controller
//   CLP_type, feature_amount current layer descriptor fields
//   featrue_mem_init_addr    read init address (128b words)
//   output_data_addr_init    write init address (256b words)
//   layer_idx                current layer index
//   err_stray_flag           sticky: output flag seen outside a layer's RUN window
module feature_layer_scheduler #(
    parameter int unsigned MAX_LAYERS = 8,
    parameter int unsigned LIDX_W     = 3,
    parameter int unsigned PING_BASE  = 0,
    parameter int unsigned PONG_BASE  = 512,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [LIDX_W-1:0] cfg_layer,
    input  logic [3:0]        cfg_clp_type,
    input  logic [9:0]        cfg_feature_amount,
    input  logic [9:0]        cfg_output_amount,
    input  logic [3:0]        num_layers,
    input  logic              start,
    input  logic              CLP_output_flag,
    output logic              busy,
    output logic              done,
    output logic              state,
    output logic [3:0]        CLP_type,
    output logic [9:0]        feature_amount,
    output logic [14:0]       featrue_mem_init_addr,
    output logic [9:0]        output_data_addr_init,
    output logic [LIDX_W-1:0] layer_idx,
    output logic              err_stray_flag
);

    localparam int unsigned N_W   = 4;
    localparam int unsigned CNT_W = 10;
    localparam int unsigned GAP_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_GAP,
        S_DONE
    } fsm_t;

    typedef struct packed {
        logic [3:0]       clp_type;
        logic [9:0]       feature_amount;
        logic [CNT_W-1:0] output_amount;
    } desc_t;

    desc_t              table_q [MAX_LAYERS];
    desc_t              table_d [MAX_LAYERS];
    fsm_t               fsm_q, fsm_d;
    logic [N_W-1:0]     n_q, n_d;
    logic [LIDX_W-1:0]  layer_idx_q, layer_idx_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]   oa_q, oa_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               state_q, state_d;
    logic [3:0]         clp_type_q, clp_type_d;
    logic [9:0]         feature_amount_q, feature_amount_d;
    logic [14:0]        rd_addr_q, rd_addr_d;
    logic [9:0]         wr_addr_q, wr_addr_d;
    logic               err_q, err_d;

    // Next-state and registered-output computation
    always_comb begin
        table_d          = table_q;
        fsm_d            = fsm_q;
        n_d              = n_q;
        layer_idx_d      = layer_idx_q;
        out_cnt_d        = out_cnt_q;
        oa_d             = oa_q;
        gap_cnt_d        = gap_cnt_q;
        busy_d           = busy_q;
        done_d           = 1'b0;
        state_d          = state_q;
        clp_type_d       = clp_type_q;
        feature_amount_d = feature_amount_q;
        rd_addr_d        = rd_addr_q;
        wr_addr_d        = wr_addr_q;
        err_d            = err_q;

        // Table is writable only while idle; a write alongside start still lands
        if (cfg_we && fsm_q == S_IDLE) begin
            table_d[cfg_layer] = '{clp_type:       cfg_clp_type,
                                   feature_amount: cfg_feature_amount,
                                   output_amount:  cfg_output_amount};
        end

        // Start clears the sticky error; a simultaneous stray flag still sets it
        if (start && fsm_q == S_IDLE) begin
            err_d = 1'b0;
        end
        if (CLP_output_flag && fsm_q != S_RUN) begin
            err_d = 1'b1;
        end

        case (fsm_q)
            S_IDLE: begin
                if (start) begin
                    n_d         = (num_layers > N_W'(MAX_LAYERS)) ? N_W'(MAX_LAYERS) : num_layers;
                    layer_idx_d = '0;
                    busy_d      = 1'b1;
                    fsm_d       = (n_d == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                clp_type_d       = table_q[layer_idx_q].clp_type;
                feature_amount_d = table_q[layer_idx_q].feature_amount;
                oa_d             = table_q[layer_idx_q].output_amount;
                // Even layers write region B and read A; odd layers swap
                if (layer_idx_q[0]) begin
                    wr_addr_d = 10'(PING_BASE);
                    rd_addr_d = {4'b0, 10'(PONG_BASE), 1'b0};
                end else begin
                    wr_addr_d = 10'(PONG_BASE);
                    rd_addr_d = {4'b0, 10'(PING_BASE), 1'b0};
                end
                out_cnt_d = '0;
                state_d   = 1'b1;
                fsm_d     = S_RUN;
            end
            S_RUN: begin
                if (CLP_output_flag) begin
                    out_cnt_d = out_cnt_q + CNT_W'(1);
                end
                // The terminating flag is counted; oa==0 layers last one cycle
                if (oa_q == '0 || (CLP_output_flag && out_cnt_q == oa_q - CNT_W'(1))) begin
                    state_d   = 1'b0;
                    gap_cnt_d = '0;
                    fsm_d     = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    if (N_W'(layer_idx_q) == n_q - N_W'(1)) begin
                        fsm_d = S_DONE;
                    end else begin
                        layer_idx_d = layer_idx_q + LIDX_W'(1);
                        fsm_d       = S_LOAD;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            S_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                fsm_d  = S_IDLE;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any layer in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MAX_LAYERS); i++) begin
                table_q[i] <= '0;
            end
            fsm_q            <= S_IDLE;
            n_q              <= '0;
            layer_idx_q      <= '0;
            out_cnt_q        <= '0;
            oa_q             <= '0;
            gap_cnt_q        <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            state_q          <= 1'b0;
            clp_type_q       <= '0;
            feature_amount_q <= '0;
            rd_addr_q        <= '0;
            wr_addr_q        <= '0;
            err_q            <= 1'b0;
        end else begin
            table_q          <= table_d;
            fsm_q            <= fsm_d;
            n_q              <= n_d;
            layer_idx_q      <= layer_idx_d;
            out_cnt_q        <= out_cnt_d;
            oa_q             <= oa_d;
            gap_cnt_q        <= gap_cnt_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            state_q          <= state_d;
            clp_type_q       <= clp_type_d;
            feature_amount_q <= feature_amount_d;
            rd_addr_q        <= rd_addr_d;
            wr_addr_q        <= wr_addr_d;
            err_q            <= err_d;
        end
    end

    assign busy                  = busy_q;
    assign done                  = done_q;
    assign state                 = state_q;
    assign CLP_type              = clp_type_q;
    assign feature_amount        = feature_amount_q;
    assign featrue_mem_init_addr = rd_addr_q;
    assign output_data_addr_init = wr_addr_q;
    assign layer_idx             = layer_idx_q;
    assign err_stray_flag        = err_q;

endmodule
